// File: rtl/oric_ram_arbiter.sv
// Shares the single-port 64 KiB Oric main RAM between the reset fill, the CPU/ULA bus and the ioctl loader.
// Loader FIFO, ioctl_wait, load_done and load_ovf exist only when ORIC_RAM_LOADER_EN is defined.
module oric_ram_arbiter #(
  parameter logic [7:0]  FILL       = 8'hFF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] cpu_ad,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  output logic [7:0]  cpu_q,
  output logic        cpu_hold,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        load_done,
  output logic        load_ovf,
  output logic [15:0] mem_ad,
  output logic [7:0]  mem_d,
  output logic        mem_we,
  input  logic [7:0]  mem_q
);

  typedef enum logic {S_FILL, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [15:0] fill_cnt_q, fill_cnt_d;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_FILL;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  assign cpu_q    = mem_q;
  assign cpu_hold = (state_q == S_FILL);

`ifdef ORIC_RAM_LOADER_EN
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [15:0] ad;
    logic [7:0]  d;
  } ld_entry_t;

  ld_entry_t        fifo_q [FIFO_DEPTH];
  ld_entry_t        head_c;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_req_c, push_c, pop_c, empty_c, full_c;
  logic             ovf_q, wait_q, done_q, dl_q, fall_pend_q;

  assign empty_c    = (count_q == '0);
  assign full_c     = (count_q == CNT_W'(FIFO_DEPTH));
  assign head_c     = fifo_q[rd_ptr_q];
  assign pop_c      = (state_q == S_RUN) && !cpu_cs && !empty_c;
  assign push_req_c = ioctl_wr && ioctl_download;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_c     = push_req_c && (!full_c || pop_c);

  always_comb begin
    count_d = count_q;
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_c) begin
      fifo_q[wr_ptr_q] <= '{ad: ioctl_addr, d: ioctl_dout};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      wait_q      <= 1'b1;
      dl_q        <= 1'b0;
      fall_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (push_req_c && !push_c) ovf_q <= 1'b1;
      // Threshold one below full covers the loader reacting a cycle late.
      wait_q  <= (count_d >= CNT_W'(FIFO_DEPTH - 1)) || (state_d == S_FILL);
      dl_q    <= ioctl_download;
      done_q  <= 1'b0;
      if (dl_q && !ioctl_download) begin
        fall_pend_q <= 1'b1;
      end else if (fall_pend_q && empty_c && (state_q == S_RUN)) begin
        fall_pend_q <= 1'b0;
        done_q      <= 1'b1;
      end
    end
  end

  assign ioctl_wait = wait_q;
  assign load_done  = done_q;
  assign load_ovf   = ovf_q;
`else
  logic unused_ioctl;
  assign unused_ioctl = ^{ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout};
  assign ioctl_wait   = 1'b0;
  assign load_done    = 1'b0;
  assign load_ovf     = 1'b0;
`endif

  // Port mux: fill owns the RAM, then CPU (combinational), then loader head.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    mem_ad     = cpu_ad;
    mem_d      = cpu_d;
    mem_we     = 1'b0;
    case (state_q)
      S_FILL: begin
        mem_ad     = fill_cnt_q;
        mem_d      = FILL;
        mem_we     = 1'b1;
        fill_cnt_d = fill_cnt_q + 16'd1;
        if (fill_cnt_q == 16'hFFFF) state_d = S_RUN;
      end
      S_RUN: begin
        if (cpu_cs) begin
          mem_we = cpu_we;
`ifdef ORIC_RAM_LOADER_EN
        end else if (pop_c) begin
          mem_ad = head_c.ad;
          mem_d  = head_c.d;
          mem_we = 1'b1;
`endif
        end
      end
      default: state_d = S_FILL;
    endcase
  end

endmodule
